if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Sequences instruction fetch for the IF stage: owns the fetch PC, issues requests on the
//  SRAM-like instruction bus, and merges exception/eret/branch redirects with downstream stall.
//  Redirects arriving mid-transaction are held pending and stale responses are discarded.
//  Sits between the instruction-side bus and the IF/ID register; replaces free-running PC update.
// PARAMETERS
//  RESET_PC   32'hbfc00000  fetch address after reset
//  EXC_VEC    32'hbfc00380  exception entry address
// PORTS
//  clk           in   1   clock, rising edge
//  resetn        in   1   asynchronous, active-low reset
//  stall         in   1   1: ID cannot accept the instruction presented this cycle
//  exception     in   1   1-cycle pulse: redirect to EXC_VEC
//  eret          in   1   1-cycle pulse: redirect to epc
//  epc           in   32  eret target
//  br_take       in   1   1-cycle pulse: redirect to br_target
//  br_target     in   32  branch target
//  inst_req      out  1   bus request
//  inst_addr     out  32  bus address, stable while inst_req=1 and inst_addr_ok=0
//  inst_addr_ok  in   1   address accepted this cycle
//  inst_data_ok  in   1   read data valid this cycle
//  inst_rdata    in   32  read data
//  if_valid      out  1   if_pc/if_inst hold a valid instruction
//  if_pc         out  32  PC of presented instruction
//  if_inst       out  32  presented instruction
// BEHAVIOUR
//  - Reset (async): state=IDLE, fetch_pc=RESET_PC, pend_v=0, discard=0, inst_req=0,
//    if_valid=0, if_pc=0, if_inst=0.
//  - Redirect priority in one cycle: exception > br_take > eret; winner target -> redirect_pc.
//  - FSM: IDLE -> REQ when output buffer free (if_valid=0, or if_valid&&!stall this cycle).
//    REQ: inst_req=1, inst_addr=fetch_pc; on inst_addr_ok -> WAIT. WAIT: on inst_data_ok -> IDLE
//    (or REQ same edge if buffer will be free). At most one transaction outstanding.
//  - Redirect in IDLE: fetch_pc<=redirect_pc next edge; no discard.
//  - Redirect in REQ without addr_ok: addr must stay stable -> latch pend_v=1, pend_pc; keep req.
//    Redirect in REQ with addr_ok, or in WAIT: discard<=1, pend_v=1, pend_pc=redirect_pc.
//  - Later redirect while pend_v=1 overwrites pend_pc (newest wins; exception still wins within cycle).
//  - Any redirect flushes output buffer: if_valid<=0 next edge regardless of stall.
//  - inst_addr_ok accepted under pend_v=1 marks that transaction discard=1.
//  - inst_data_ok with discard=1: drop data, discard<=0, next request uses pend_pc, pend_v<=0.
//  - inst_data_ok with discard=0: if_valid<=1, if_pc<=txn_pc, if_inst<=inst_rdata;
//    fetch_pc<=txn_pc+4 (32-bit wrap, no overflow check).
//  - Presented instruction held unchanged while stall=1; consumed on cycle if_valid&&!stall.
//  - data_ok same cycle as redirect: data dropped, redirect honoured.
//  - Reset mid-transaction: all state cleared; bus assumed reset together.
// TESTING
//  1. Release reset, bus addr_ok/data_ok in 1 cycle each, stall=0 -> addrs bfc00000, bfc00004, ...;
//     if_pc follows with if_inst=rdata.
//  2. stall=1 for 5 cycles with if_valid=1 -> if_pc/if_inst constant, no new inst_req issued.
//  3. br_take (target 0x80001000) during WAIT -> returned data dropped (if_valid stays 0),
//     next inst_addr=0x80001000.
//  4. br_take+exception same cycle while addr_ok withheld -> inst_addr unchanged until addr_ok,
//     that txn discarded, next inst_addr=0xbfc00380.
//  5. eret (epc=0x80002000) in IDLE -> next inst_addr=0x80002000, no discard.
//  6. resetn low mid-WAIT -> inst_req=0, if_valid=0 immediately; first req after release = bfc00000.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - SRAM-like instruction bus between fetch control and memory side
interface if_fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer: owns fetch PC, one outstanding bus read,
// redirect merging with pending/discard tracking, single-entry output buffer toward ID.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EXC_VEC  = 32'hbfc00380
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   stall,
    input  logic                   exception,
    input  logic                   eret,
    input  logic [31:0]            epc,
    input  logic                   br_take,
    input  logic [31:0]            br_target,
    if_fetch_ctrl_if.master        bus,
    output logic                   if_valid,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_inst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic        pend_v;
    logic        discard;
    logic        req_q;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        buf_free;

    always_comb begin
        redirect    = exception | br_take | eret;
        redirect_pc = fetch_pc;
        if (exception)
            redirect_pc = EXC_VEC;
        else if (br_take)
            redirect_pc = br_target;
        else if (eret)
            redirect_pc = epc;
        buf_free = !if_valid || !stall;
    end

    // fetch_pc only moves when no address is on the bus, so it doubles as the txn PC
    assign bus.inst_req  = req_q;
    assign bus.inst_addr = fetch_pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            pend_pc  <= 32'h0;
            pend_v   <= 1'b0;
            discard  <= 1'b0;
            req_q    <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_inst  <= 32'h0;
        end else begin
            if (redirect) begin
                if_valid <= 1'b0;
            end else if (state == WAIT && bus.inst_data_ok && !discard) begin
                if_valid <= 1'b1;
                if_pc    <= fetch_pc;
                if_inst  <= bus.inst_rdata;
            end else if (if_valid && !stall) begin
                if_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (buf_free) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.inst_addr_ok) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                        if (redirect || pend_v)
                            discard <= 1'b1;
                    end
                    if (redirect) begin
                        pend_v  <= 1'b1;
                        pend_pc <= redirect_pc;
                    end
                end
                WAIT: begin
                    if (bus.inst_data_ok) begin
                        pend_v  <= 1'b0;
                        discard <= 1'b0;
                        if (redirect) begin
                            fetch_pc <= redirect_pc;
                            state    <= IDLE;
                        end else if (discard) begin
                            // buffer was flushed by the redirect, so refetch immediately
                            fetch_pc <= pend_pc;
                            state    <= REQ;
                            req_q    <= 1'b1;
                        end else begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= IDLE;
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                        pend_v  <= 1'b1;
                        pend_pc <= redirect_pc;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl with transaction-level model
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC  = 32'hbfc00380;
    localparam logic [31:0] RKEY     = 32'hdeadbeef;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall, exception, eret, br_take;
    logic [31:0] epc, br_target;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    if_fetch_ctrl_if bus();

    if_fetch_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .stall     (stall),
        .exception (exception),
        .eret      (eret),
        .epc       (epc),
        .br_take   (br_take),
        .br_target (br_target),
        .bus       (bus),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory-side responder: addr_ok as soon as a request is seen, data data_lat cycles later
    bit          hold_addr = 1'b0;
    int          data_lat  = 1;
    bit          outstanding = 1'b0;
    int          dcnt;
    logic [31:0] oaddr;

    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.inst_addr_ok = 1'b0;
            bus.inst_data_ok = 1'b0;
            if (!resetn) begin
                outstanding = 1'b0;
            end else if (outstanding) begin
                if (dcnt == 0) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = oaddr ^ RKEY;
                    outstanding      = 1'b0;
                end else begin
                    dcnt--;
                end
            end else if (bus.inst_req && !hold_addr) begin
                bus.inst_addr_ok = 1'b1;
                outstanding      = 1'b1;
                oaddr            = bus.inst_addr;
                dcnt             = data_lat - 1;
            end
        end
    end

    // transaction-level model: next expected fetch address, fate of the open transaction,
    // and the contents of the one-entry presentation buffer
    logic [31:0] exp_addr, txn_addr, m_pc, m_inst, tgt;
    bit          txn_active, txn_acc, txn_disc, m_v, prev_free, redir, deliver;
    logic [31:0] req_log[$];
    logic [31:0] pres_pc[$];
    logic [31:0] pres_inst[$];

    always @(negedge clk) begin
        if (!resetn) begin
            check32("rst_inst_req", {31'b0, bus.inst_req}, 32'd0);
            check32("rst_if_valid", {31'b0, if_valid}, 32'd0);
            check32("rst_if_pc", if_pc, 32'h0);
            check32("rst_if_inst", if_inst, 32'h0);
            exp_addr   = RESET_PC;
            txn_active = 1'b0;
            m_v        = 1'b0;
            prev_free  = 1'b1;
        end else begin
            redir = exception | br_take | eret;
            tgt   = exception ? EXC_VEC : (br_take ? br_target : epc);

            check32("if_valid", {31'b0, if_valid}, {31'b0, m_v});
            if (m_v) begin
                check32("if_pc", if_pc, m_pc);
                check32("if_inst", if_inst, m_inst);
            end

            if (bus.inst_req) begin
                if (!txn_active) begin
                    check32("req_addr", bus.inst_addr, exp_addr);
                    check32("req_buf_free", {31'b0, prev_free}, 32'd1);
                    req_log.push_back(bus.inst_addr);
                    txn_active = 1'b1;
                    txn_acc    = 1'b0;
                    txn_disc   = 1'b0;
                    txn_addr   = bus.inst_addr;
                end else if (!txn_acc) begin
                    check32("addr_stable", bus.inst_addr, txn_addr);
                end else begin
                    check32("one_outstanding", {31'b0, bus.inst_req}, 32'd0);
                end
                if (bus.inst_addr_ok)
                    txn_acc = 1'b1;
            end

            deliver = 1'b0;
            if (bus.inst_data_ok && txn_active && txn_acc) begin
                if (!txn_disc && !redir) begin
                    deliver  = 1'b1;
                    exp_addr = txn_addr + 32'd4;
                    pres_pc.push_back(txn_addr);
                    pres_inst.push_back(bus.inst_rdata);
                end
                txn_active = 1'b0;
            end
            if (redir) begin
                exp_addr = tgt;
                txn_disc = 1'b1;
            end

            prev_free = !m_v || !stall;
            if (redir) begin
                m_v = 1'b0;
            end else if (deliver) begin
                m_v    = 1'b1;
                m_pc   = txn_addr;
                m_inst = bus.inst_rdata;
            end else if (m_v && !stall) begin
                m_v = 1'b0;
            end
        end
    end

    task automatic wait_reqs(input int n);
        for (int i = 0; i < 100 && req_log.size() < n; i++) @(negedge clk);
        check32("wait_req", {31'b0, req_log.size() >= n}, 32'd1);
    endtask

    task automatic wait_pres(input int n);
        for (int i = 0; i < 100 && pres_pc.size() < n; i++) @(negedge clk);
        check32("wait_pres", {31'b0, pres_pc.size() >= n}, 32'd1);
    endtask

    task automatic wait_hs();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.inst_req && bus.inst_addr_ok) break;
        end
        check32("wait_hs", {31'b0, i < 100}, 32'd1);
    endtask

    int n, p;

    initial begin
        resetn = 1'b0; stall = 1'b0; exception = 1'b0; eret = 1'b0; br_take = 1'b0;
        epc = 32'h0; br_target = 32'h0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // sequential fetch with single-cycle bus
        wait_reqs(4);
        check32("t1_addr0", req_log[0], 32'hbfc00000);
        check32("t1_addr1", req_log[1], 32'hbfc00004);
        check32("t1_addr2", req_log[2], 32'hbfc00008);
        check32("t1_pc0", pres_pc[0], 32'hbfc00000);
        check32("t1_inst0", pres_inst[0], 32'h616dbeef);
        check32("t1_inst1", pres_inst[1], 32'h616dbeeb);

        // stall holds the presented instruction and blocks new requests
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 100 && !if_valid; i++) @(negedge clk);
        n = req_log.size();
        repeat (5) @(negedge clk);
        check32("t2_no_req", req_log.size(), n);
        stall = 1'b0;

        // branch while waiting for data: response dropped
        data_lat = 3;
        wait_hs();
        @(posedge clk); #1;
        br_take = 1'b1; br_target = 32'h80001000;
        n = req_log.size();
        p = pres_pc.size();
        @(posedge clk); #1;
        br_take = 1'b0;
        wait_reqs(n + 1);
        check32("t3_next_addr", req_log[n], 32'h80001000);
        check32("t3_dropped", pres_pc.size(), p);

        // exception + branch while addr_ok is withheld: exception wins, held txn discarded
        data_lat = 1;
        @(negedge clk);
        hold_addr = 1'b1;
        for (int i = 0; i < 100 && !(bus.inst_req && !bus.inst_addr_ok); i++) @(negedge clk);
        @(posedge clk); #1;
        exception = 1'b1; br_take = 1'b1; br_target = 32'h80004000;
        @(posedge clk); #1;
        exception = 1'b0; br_take = 1'b0;
        repeat (3) @(negedge clk);
        n = req_log.size();
        hold_addr = 1'b0;
        wait_reqs(n + 1);
        check32("t4_next_addr", req_log[n], 32'hbfc00380);

        // eret while idle (buffer full and stalled): no discard
        @(negedge clk);
        stall = 1'b1;
        do @(negedge clk); while (!if_valid && $time < 100000);
        @(posedge clk); #1;
        eret = 1'b1; epc = 32'h80002000;
        n = req_log.size();
        p = pres_pc.size();
        @(posedge clk); #1;
        eret = 1'b0; stall = 1'b0;
        wait_reqs(n + 1);
        check32("t5_next_addr", req_log[n], 32'h80002000);
        wait_pres(p + 1);
        check32("t5_pc", pres_pc[p], 32'h80002000);
        check32("t5_inst", pres_inst[p], 32'h5ead9eef);

        // asynchronous reset in the middle of a transaction
        data_lat = 4;
        wait_hs();
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check32("t6_req_now", {31'b0, bus.inst_req}, 32'd0);
        check32("t6_valid_now", {31'b0, if_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        n = req_log.size();
        wait_reqs(n + 1);
        check32("t6_first_addr", req_log[n], 32'hbfc00000);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
